// File: rtl/mem_wb_stage.sv
// Writeback stage of the CK_riscv 5-stage core: retires MEM-stage instructions,
// waits for load responses, aligns/extends load data and drives the register-file write port.
module mem_wb_stage #(
    parameter int unsigned LOAD_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid_i,
    output logic             mem_ready_o,
    input  logic             mem_rd_wen_i,
    input  logic [4:0]       mem_rd_addr_i,
    input  logic [1:0]       mem_wb_sel_i,
    input  logic [31:0]      mem_alu_result_i,
    input  logic [31:0]      mem_pc_plus4_i,
    input  logic [2:0]       mem_funct3_i,
    input  logic [1:0]       mem_addr_lo_i,
    input  logic             dmem_rvalid_i,
    input  logic [31:0]      dmem_rdata_i,
    output logic             wr_reg_en,
    output logic [4:0]       wr_reg_addr,
    output logic [31:0]      wr_wdata,
    output logic             load_err_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    localparam int unsigned     TO_W    = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOAD_TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic            ld_wen_q, ld_wen_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic [2:0]      ld_funct3_q, ld_funct3_d;
    logic [1:0]      ld_off_q, ld_off_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic             wr_en_q, wr_en_d;
    logic [4:0]       wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] retire_q, retire_d;

    logic [31:0] load_data;

    function automatic logic [31:0] load_extract(
        input logic [2:0]  funct3,
        input logic [1:0]  off,
        input logic [31:0] rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        // Halfword lane picked by off[1] only; misaligned off[0] is ignored.
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = rdata;
            3'b100:  res = {24'h0, b};
            3'b101:  res = {16'h0, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    assign load_data   = load_extract(ld_funct3_q, ld_off_q, dmem_rdata_i);
    assign mem_ready_o = (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        ld_wen_d    = ld_wen_q;
        ld_rd_d     = ld_rd_q;
        ld_funct3_d = ld_funct3_q;
        ld_off_d    = ld_off_q;
        to_cnt_d    = to_cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_d       = 1'b0;
        retire_d    = retire_q;

        case (state_q)
            IDLE: begin
                if (mem_valid_i) begin
                    if (mem_wb_sel_i == 2'd1) begin
                        ld_wen_d    = mem_rd_wen_i;
                        ld_rd_d     = mem_rd_addr_i;
                        ld_funct3_d = mem_funct3_i;
                        ld_off_d    = mem_addr_lo_i;
                        to_cnt_d    = '0;
                        state_d     = WAIT_LOAD;
                    end else begin
                        wr_en_d   = mem_rd_wen_i & (mem_rd_addr_i != 5'd0);
                        wr_addr_d = mem_rd_addr_i;
                        wr_data_d = (mem_wb_sel_i == 2'd2) ? mem_pc_plus4_i : mem_alu_result_i;
                        retire_d  = retire_q + CNT_W'(1);
                    end
                end
            end
            WAIT_LOAD: begin
                // A response on the expiry cycle still completes normally.
                if (dmem_rvalid_i) begin
                    wr_en_d   = ld_wen_q & (ld_rd_q != 5'd0);
                    wr_addr_d = ld_rd_q;
                    wr_data_d = load_data;
                    retire_d  = retire_q + CNT_W'(1);
                    state_d   = IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ld_wen_q    <= 1'b0;
            ld_rd_q     <= '0;
            ld_funct3_q <= '0;
            ld_off_q    <= '0;
            to_cnt_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_q       <= 1'b0;
            retire_q    <= '0;
        end else begin
            state_q     <= state_d;
            ld_wen_q    <= ld_wen_d;
            ld_rd_q     <= ld_rd_d;
            ld_funct3_q <= ld_funct3_d;
            ld_off_q    <= ld_off_d;
            to_cnt_q    <= to_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            err_q       <= err_d;
            retire_q    <= retire_d;
        end
    end

    assign wr_reg_en    = wr_en_q;
    assign wr_reg_addr  = wr_addr_q;
    assign wr_wdata     = wr_data_q;
    assign load_err_o   = err_q;
    assign retire_cnt_o = retire_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a cycle-indexed expectation schedule built from
// transaction timing rules, checked every cycle, plus hand-computed literal values.
module tb_mem_wb_stage;

    localparam int unsigned LT   = 16;
    localparam int unsigned NCYC = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_valid_i = 1'b0;
    logic        mem_ready_o;
    logic        mem_rd_wen_i = 1'b0;
    logic [4:0]  mem_rd_addr_i = '0;
    logic [1:0]  mem_wb_sel_i = '0;
    logic [31:0] mem_alu_result_i = '0;
    logic [31:0] mem_pc_plus4_i = '0;
    logic [2:0]  mem_funct3_i = '0;
    logic [1:0]  mem_addr_lo_i = '0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        wr_reg_en;
    logic [4:0]  wr_reg_addr;
    logic [31:0] wr_wdata;
    logic        load_err_o;
    logic [31:0] retire_cnt_o;

    mem_wb_stage #(.LOAD_TIMEOUT(LT), .CNT_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_valid_i      (mem_valid_i),
        .mem_ready_o      (mem_ready_o),
        .mem_rd_wen_i     (mem_rd_wen_i),
        .mem_rd_addr_i    (mem_rd_addr_i),
        .mem_wb_sel_i     (mem_wb_sel_i),
        .mem_alu_result_i (mem_alu_result_i),
        .mem_pc_plus4_i   (mem_pc_plus4_i),
        .mem_funct3_i     (mem_funct3_i),
        .mem_addr_lo_i    (mem_addr_lo_i),
        .dmem_rvalid_i    (dmem_rvalid_i),
        .dmem_rdata_i     (dmem_rdata_i),
        .wr_reg_en        (wr_reg_en),
        .wr_reg_addr      (wr_reg_addr),
        .wr_wdata         (wr_wdata),
        .load_err_o       (load_err_o),
        .retire_cnt_o     (retire_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expectation schedule indexed by cycle (cycle n = interval after the n-th rising edge).
    bit          exp_comp [NCYC];
    bit          exp_en   [NCYC];
    bit          exp_err  [NCYC];
    bit          exp_busy [NCYC];
    logic [4:0]  exp_addr [NCYC];
    logic [31:0] exp_data [NCYC];
    bit          lit_v    [NCYC];
    logic [31:0] lit_d    [NCYC];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] result_of(input logic [1:0] sel, input logic [31:0] alu,
                                              input logic [31:0] pc4);
        if (sel == 2'd2) return pc4;
        return alu;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        int unsigned o, b, h;
        o = off;
        b = (w >> (8 * o)) & 32'hFF;
        h = (w >> ((o >= 2) ? 16 : 0)) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? (b + 32'hFFFFFF00) : b;
            3'b001:  return (h >= 32768) ? (h + 32'hFFFF0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic expect_retire(input int c, input bit en, input logic [4:0] rd, input logic [31:0] d);
        exp_comp[c] = 1'b1;
        exp_en[c]   = en;
        exp_addr[c] = rd;
        exp_data[c] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [1:0] sel, input logic wen, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] pc4,
                          input bit use_lit, input logic [31:0] lit);
        int c;
        c = cyc;
        mem_valid_i = 1'b1;
        mem_wb_sel_i = sel;
        mem_rd_wen_i = wen;
        mem_rd_addr_i = rd;
        mem_alu_result_i = alu;
        mem_pc_plus4_i = pc4;
        expect_retire(c + 1, wen && (rd != 5'd0), rd, result_of(sel, alu, pc4));
        if (use_lit) begin
            lit_v[c + 1] = 1'b1;
            lit_d[c + 1] = lit;
        end
        tick();
        mem_valid_i = 1'b0;
    endtask

    // delay = cycles after accept at which rvalid is driven; delay > LT means no response.
    task automatic load_op(input logic [2:0] f3, input logic [1:0] off, input logic wen,
                           input logic [4:0] rd, input logic [31:0] rdata, input int delay,
                           input bit hold_alu, input logic [4:0] ard, input logic [31:0] aval,
                           input bit use_lit, input logic [31:0] lit);
        int a;
        int wait_len;
        bit responds;
        a = cyc;
        responds = (delay <= int'(LT));
        wait_len = responds ? delay : int'(LT);
        mem_valid_i = 1'b1;
        mem_wb_sel_i = 2'd1;
        mem_rd_wen_i = wen;
        mem_rd_addr_i = rd;
        mem_funct3_i = f3;
        mem_addr_lo_i = off;
        mem_alu_result_i = 32'h0BAD_0BAD;
        for (int k = 1; k <= wait_len; k++) exp_busy[a + k] = 1'b1;
        if (responds) begin
            expect_retire(a + delay + 1, wen && (rd != 5'd0), rd, model_load(f3, off, rdata));
            if (use_lit) begin
                lit_v[a + delay + 1] = 1'b1;
                lit_d[a + delay + 1] = lit;
            end
        end else begin
            exp_err[a + int'(LT) + 1] = 1'b1;
        end
        tick();
        if (hold_alu) begin
            mem_valid_i = 1'b1;
            mem_wb_sel_i = 2'd0;
            mem_rd_wen_i = 1'b1;
            mem_rd_addr_i = ard;
            mem_alu_result_i = aval;
        end else begin
            mem_valid_i = 1'b0;
            mem_rd_wen_i = ~wen;
            mem_rd_addr_i = ~rd;
            mem_wb_sel_i = 2'd0;
        end
        mem_funct3_i = ~f3;
        mem_addr_lo_i = ~off;
        for (int k = 1; k <= wait_len; k++) begin
            dmem_rvalid_i = responds && (k == delay);
            dmem_rdata_i = dmem_rvalid_i ? rdata : 32'hDEAD_BEEF ^ 32'(k);
            tick();
        end
        dmem_rvalid_i = 1'b0;
        if (hold_alu) begin
            expect_retire(a + wait_len + 2, ard != 5'd0, ard, aval);
            tick();
        end
        mem_valid_i = 1'b0;
    endtask

    initial begin : compare
        logic [31:0] exp_cnt;
        exp_cnt = '0;
        forever begin
            @(negedge clk);
            if (cyc < int'(NCYC)) begin
                if (!rst_n) exp_cnt = '0;
                else if (exp_comp[cyc]) exp_cnt = exp_cnt + 32'd1;
                check("wr_reg_en", 32'(wr_reg_en), 32'(rst_n && exp_en[cyc]));
                check("load_err", 32'(load_err_o), 32'(rst_n && exp_err[cyc]));
                check("mem_ready", 32'(mem_ready_o), (rst_n && exp_busy[cyc]) ? 32'd0 : 32'd1);
                check("retire_cnt", retire_cnt_o, exp_cnt);
                if (rst_n && exp_comp[cyc]) begin
                    check("wr_reg_addr", 32'(wr_reg_addr), 32'(exp_addr[cyc]));
                    check("wr_wdata", wr_wdata, exp_data[cyc]);
                end
                if (rst_n && lit_v[cyc]) check("wr_wdata_literal", wr_wdata, lit_d[cyc]);
            end
        end
    end

    initial begin : watchdog
        #(NCYC * 10);
        n_fail++;
        $display("FAIL watchdog: cycle budget %0d exhausted", NCYC);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : driver
        int a;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_addr", 32'(wr_reg_addr), 32'd0);
        check("reset_data", wr_wdata, 32'd0);
        tick();
        rst_n = 1'b1;

        alu_op(2'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 1'b1, 32'h1234_5678);
        @(negedge clk);
        check("retire_after_first", retire_cnt_o, 32'd1);
        alu_op(2'd2, 1'b1, 5'd0, 32'h0000_AAAA, 32'h0000_0080, 1'b0, 32'h0);
        alu_op(2'd2, 1'b1, 5'd1, 32'h0000_AAAA, 32'h0000_0080, 1'b1, 32'h0000_0080);
        alu_op(2'd3, 1'b1, 5'd9, 32'h5555_0009, 32'h0000_0100, 1'b1, 32'h5555_0009);
        alu_op(2'd0, 1'b0, 5'd10, 32'h7777_7777, 32'h0, 1'b0, 32'h0);
        tick();

        load_op(3'b000, 2'd0, 1'b1, 5'd11, 32'h8001_F280, 1, 1'b0, 5'd0, 32'h0, 1'b1, 32'hFFFF_FF80);
        load_op(3'b100, 2'd1, 1'b1, 5'd12, 32'h8001_F280, 2, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_00F2);
        load_op(3'b001, 2'd2, 1'b1, 5'd13, 32'h8001_F280, 3, 1'b0, 5'd0, 32'h0, 1'b1, 32'hFFFF_8001);
        load_op(3'b101, 2'd0, 1'b1, 5'd14, 32'h8001_F280, 1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_F280);
        load_op(3'b010, 2'd0, 1'b1, 5'd15, 32'h8001_F280, 4, 1'b0, 5'd0, 32'h0, 1'b1, 32'h8001_F280);
        load_op(3'b000, 2'd3, 1'b1, 5'd16, 32'h8001_F280, 2, 1'b0, 5'd0, 32'h0, 1'b1, 32'hFFFF_FF80);
        load_op(3'b001, 2'd3, 1'b1, 5'd17, 32'h8001_F280, 1, 1'b0, 5'd0, 32'h0, 1'b1, 32'hFFFF_8001);
        load_op(3'b100, 2'd2, 1'b1, 5'd18, 32'h8001_F280, 1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_0001);
        load_op(3'b011, 2'd1, 1'b1, 5'd19, 32'h1357_9BDF, 2, 1'b0, 5'd0, 32'h0, 1'b1, 32'h1357_9BDF);
        load_op(3'b010, 2'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        load_op(3'b010, 2'd0, 1'b0, 5'd20, 32'h2468_ACE0, 2, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);

        load_op(3'b010, 2'd0, 1'b1, 5'd21, 32'hA5A5_0001, 5, 1'b1, 5'd7, 32'hCAFE_0001, 1'b1, 32'hA5A5_0001);
        tick();

        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'h1111_2222;
        repeat (3) tick();
        dmem_rvalid_i = 1'b0;

        load_op(3'b010, 2'd0, 1'b1, 5'd22, 32'h0, 100, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        tick();
        load_op(3'b010, 2'd0, 1'b1, 5'd23, 32'h0, 100, 1'b1, 5'd24, 32'h0000_0024, 1'b0, 32'h0);
        load_op(3'b000, 2'd1, 1'b1, 5'd25, 32'h0000_7F00, int'(LT), 1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_007F);
        tick();

        a = cyc;
        mem_valid_i = 1'b1;
        mem_wb_sel_i = 2'd1;
        mem_rd_wen_i = 1'b1;
        mem_rd_addr_i = 5'd26;
        mem_funct3_i = 3'b010;
        mem_addr_lo_i = 2'd0;
        exp_busy[a + 1] = 1'b1;
        exp_busy[a + 2] = 1'b1;
        tick();
        mem_valid_i = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("midload_reset_addr", 32'(wr_reg_addr), 32'd0);
        check("midload_reset_data", wr_wdata, 32'd0);
        check("midload_reset_cnt", retire_cnt_o, 32'd0);
        tick();
        rst_n = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'h9999_9999;
        repeat (2) tick();
        dmem_rvalid_i = 1'b0;
        tick();
        alu_op(2'd0, 1'b1, 5'd27, 32'h0000_0027, 32'h0, 1'b1, 32'h0000_0027);
        @(negedge clk);
        check("retire_after_reset", retire_cnt_o, 32'd1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Writeback stage of the CK_riscv 5-stage core; sits between the MEM stage and the register file.
- Accepts one retiring instruction per handshake from MEM.
- For loads, waits for the data-memory read response, then aligns and sign/zero-extends the data.
- Drives the register-file write port (`wr_reg_en` / `wr_reg_addr` / `wr_wdata`) as a registered one-cycle pulse per retired instruction, and back-pressures MEM while a load is outstanding.

Parameters:
- `LOAD_TIMEOUT`, 16, max cycles spent in WAIT_LOAD before the load is abandoned (must be >= 2).
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `mem_valid_i`  in  1  MEM stage presents an instruction
- `mem_ready_o`  out  1  stage can accept; handshake = `mem_valid_i` & `mem_ready_o`
- `mem_rd_wen_i`  in  1  instruction writes rd
- `mem_rd_addr_i`  in  5  destination register
- `mem_wb_sel_i`  in  2  result select: 0 ALU, 1 load, 2 PC+4, 3 reserved (treated as ALU)
- `mem_alu_result_i`  in  32  ALU result
- `mem_pc_plus4_i`  in  32  link value for JAL/JALR
- `mem_funct3_i`  in  3  load type
- `mem_addr_lo_i`  in  2  load byte offset (`addr[1:0]`)
- `dmem_rvalid_i`  in  1  data-memory read response valid
- `dmem_rdata_i`  in  32  data-memory read word
- `wr_reg_en`  out  1  register-file write enable
- `wr_reg_addr`  out  5  register-file write address
- `wr_wdata`  out  32  register-file write data
- `load_err_o`  out  1  one-cycle pulse: load timed out
- `retire_cnt_o`  out  CNT_W  count of retired instructions

Behaviour:
- Reset (async, `rst_n` low):
  - FSM goes to IDLE.
  - `wr_reg_en`=0, `wr_reg_addr`=0, `wr_wdata`=0, `load_err_o`=0, `retire_cnt_o`=0.
  - Timeout counter and captured fields cleared.
  - Reset mid-load discards the pending load; no write occurs after release.
- FSM states: IDLE, WAIT_LOAD.
- `mem_ready_o` = (state == IDLE), decoded combinationally from state.
- All other outputs are registered.
- IDLE, handshake with `mem_wb_sel_i` != 1:
  - Next cycle: `wr_reg_en` = `mem_rd_wen_i` & (`mem_rd_addr_i` != 0).
  - `wr_reg_addr` = rd; `wr_wdata` = PC+4 if sel=2, else ALU result.
  - `retire_cnt_o` += 1. Stay in IDLE. Latency 1 cycle; back-to-back acceptance allowed every cycle.
- IDLE, handshake with sel=1:
  - Capture rd, wen, funct3 and offset; go to WAIT_LOAD; clear the timeout counter.
  - `wr_reg_en` = 0 next cycle.
- WAIT_LOAD, each cycle:
  - If `dmem_rvalid_i`: next cycle `wr_reg_en` = wen & (rd != 0) with the extracted data; `retire_cnt_o` += 1; go to IDLE.
  - Else the counter increments. When it reaches LOAD_TIMEOUT-1 without rvalid: next cycle `load_err_o`=1 for one cycle, no write, no retire increment, go to IDLE.
  - rvalid in the same cycle as timeout expiry: rvalid wins (normal write, no error).
- A response never arrives in the handshake cycle; the earliest response is 1 cycle after accept.
- `dmem_rvalid_i` in IDLE is ignored.
- Load extraction (off = captured offset; B = `rdata[8*off+7 : 8*off]`; H = `off[1]` ? `rdata[31:16]` : `rdata[15:0]`):
  - 000 LB: sign-extend B.
  - 001 LH: sign-extend H; `off[0]` is ignored.
  - 010 LW: rdata.
  - 100 LBU: zero-extend B.
  - 101 LHU: zero-extend H.
  - Other encodings: rdata unmodified.
- x0 protection: the stage never asserts `wr_reg_en` with `wr_reg_addr`=0; `wr_reg_addr`/`wr_wdata` still update.
- `wr_reg_en` is deasserted in every cycle that does not follow a completing instruction.
- `retire_cnt_o` wraps modulo 2^CNT_W and counts retired instructions whether or not they write.
- `mem_valid_i` held while not ready: the stage does not sample it; MEM keeps its fields stable.

Test Plan:
- ALU write: sel=0, rd=5, wen=1, alu=0x1234_5678 -> next cycle `wr_reg_en`=1, addr=5, data=0x12345678; `retire_cnt_o`=1.
- x0 suppression and link: sel=2, rd=0, wen=1, pc4=0x80 -> `wr_reg_en`=0, `retire_cnt_o` increments. Repeat with rd=1 -> write 0x80 to x1.
- Load extraction:
  - rdata=0x8001_F280, LB off=0 -> 0xFFFFFF80.
  - LBU off=1 -> 0x000000F2.
  - LH off=2 -> 0xFFFF8001.
  - LHU off=0 -> 0x0000F280.
  - LW -> 0x8001F280.
  - For each: `mem_ready_o`=0 from the cycle after accept until the cycle after rvalid.
- Back-pressure: load accepted, rvalid after 5 cycles, ALU op held valid meanwhile -> ALU op accepted only after the load writes; writes appear in order.
- Timeout, LOAD_TIMEOUT=16: no rvalid -> `load_err_o` pulses once, no write, `retire_cnt_o` unchanged, ready returns. Rvalid exactly on the expiry cycle -> normal write, no error.
- Reset mid-load: assert `rst_n` low in WAIT_LOAD, then send rvalid after release -> all outputs 0, state IDLE, rvalid ignored, no write.
